// File: rtl/pll_reset_ctrl.sv
// Purpose : reset sequencer for the PLL output clock domain. It synchronises the PLL
//           lock flag, qualifies it over a stable window, then releases a stretched reset.
// Latency : release SYNC_STAGES+LOCK_CYCLES+HOLD_CYCLES edges after locked is first sampled
//           high; a lock loss in RUN re-asserts rst_out on the 3rd edge (SYNC_STAGES=2) from the drop.
// Backpressure: none. This is a free-running control block with no handshakes.
//
// Ports:
//   clk         PLL output clock; all state changes on its rising edge
//   rst         synchronous active-high reset, highest priority in every state
//   locked      PLL lock flag, asynchronous to clk
//   rst_out     registered active-high reset for the PLL clock domain
//   ready       registered complement of rst_out
//   locked_sync last synchroniser stage (debug)
//   lost_cnt    saturating count of lock losses seen while running

module pll_reset_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       rst_out,
  output logic       ready,
  output logic       locked_sync,
  output logic [7:0] lost_cnt
);

  // One down-counter is shared by QUALIFY and HOLD, so it is sized for the longer window.
  localparam int MAX_CYC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    QUALIFY,
    HOLD,
    RUN
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   lost_inc;
  logic [SYNC_STAGES-1:0] sync_q;

  assign locked_sync = sync_q[SYNC_STAGES-1];

  // Next-state logic. A low locked_sync in any timed state drops back to WAIT_LOCK.
  // The window restarts from its full length on the next rise, so there is no partial credit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lost_inc  = 1'b0;
    case (state)
      RESET: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_sync) begin
          cnt_nxt   = LOCK_LOAD;
          state_nxt = QUALIFY;
        end
      end
      QUALIFY: begin
        if (!locked_sync) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == '0) begin
          cnt_nxt   = HOLD_LOAD;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (!locked_sync) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      RUN: begin
        // Only a loss from RUN is a real outage of the downstream domain, so only this path counts.
        if (!locked_sync) begin
          lost_inc  = 1'b1;
          state_nxt = WAIT_LOCK;
        end
      end
      default: begin
        state_nxt = RESET;
        cnt_nxt   = '0;
      end
    endcase
  end

  // rst_out and ready are registered from the next state. They therefore change on the
  // same edge as the state transition, and lost_cnt moves on that edge too.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state    <= RESET;
      cnt      <= '0;
      rst_out  <= 1'b1;
      ready    <= 1'b0;
      lost_cnt <= 8'd0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], locked};
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rst_out <= (state_nxt != RUN);
      ready   <= (state_nxt == RUN);
      if (lost_inc && (lost_cnt != 8'hFF)) begin
        lost_cnt <= lost_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl. It runs one small instance (SYNC_STAGES=2, LOCK_CYCLES=8, HOLD_CYCLES=4)
// and one instance with default parameters. Inputs change 1 time unit after the rising edge,
// and outputs are checked at the same point.
module tb_pll_reset_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       locked;
  logic       rst_out;
  logic       ready;
  logic       locked_sync;
  logic [7:0] lost_cnt;

  logic       rst_d;
  logic       locked_d;
  logic       rst_out_d;
  logic       ready_d;
  logic       locked_sync_d;
  logic [7:0] lost_cnt_d;

  pll_reset_ctrl #(
    .SYNC_STAGES(2),
    .LOCK_CYCLES(8),
    .HOLD_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .rst_out    (rst_out),
    .ready      (ready),
    .locked_sync(locked_sync),
    .lost_cnt   (lost_cnt)
  );

  pll_reset_ctrl dut_def (
    .clk        (clk),
    .rst        (rst_d),
    .locked     (locked_d),
    .rst_out    (rst_out_d),
    .ready      (ready_d),
    .locked_sync(locked_sync_d),
    .lost_cnt   (lost_cnt_d)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       locked;
    logic       e_ro;
    logic       e_sync;
    logic [7:0] e_lost;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic r, input logic l,
                     input logic ro, input logic sy, input logic [7:0] lc);
    vec_t v;
    v.name   = n;
    v.rst    = r;
    v.locked = l;
    v.e_ro   = ro;
    v.e_sync = sy;
    v.e_lost = lc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string n, input logic ro, input logic [7:0] lc);
    chk({n, ".rst_out"}, int'(rst_out), int'(ro));
    chk({n, ".ready"}, int'(ready), int'(!ro));
    chk({n, ".lost_cnt"}, int'(lost_cnt), int'(lc));
  endtask

  // This task covers a one-cycle drop of locked from RUN and its recovery. L1 is the edge that
  // first samples locked low, and L2 is the next edge, which samples it high again.
  // rst_out rises on the 3rd edge from the drop (L3) together with the lost_cnt update.
  // Release follows 14 edges after L2.
  task automatic loss_cycle(input int prev_lost, input int new_lost);
    locked = 1'b0;
    step();
    chk_outs("loss.l1", 1'b0, 8'(prev_lost));
    locked = 1'b1;
    step();
    chk_outs("loss.l2", 1'b0, 8'(prev_lost));
    step();
    chk_outs("loss.l3", 1'b1, 8'(new_lost));
    repeat (12) step();
    chk_outs("loss.hold", 1'b1, 8'(new_lost));
    step();
    chk_outs("loss.release", 1'b0, 8'(new_lost));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst      = 1'b1;
    locked   = 1'b0;
    rst_d    = 1'b1;
    locked_d = 1'b0;

    // Power-up: 3 reset cycles, then locked rises at k=0. Release falls on k=14.
    for (int i = 0; i < 3; i++) add("pwr.rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    add("pwr.idle", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 17; k++) add("pwr.lock", 1'b0, 1'b1, (k < 14), (k >= 1), 8'd0);

    // Glitch in QUALIFY: locked is low at k=5 only. It is re-sampled high at k=6, so release moves to k=20.
    for (int i = 0; i < 2; i++) add("glitch.rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    add("glitch.idle", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 29; k++)
      add("glitch", 1'b0, (k != 5), (k < 20), ((k >= 1) && (k != 6)), 8'd0);

    // Loss in RUN: two low cycles. rst_out and lost_cnt step on the 3rd edge from the drop,
    // and release follows 14 edges after recovery.
    add("lossrun.l1", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    add("lossrun.l2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int m = 0; m < 17; m++) add("lossrun", 1'b0, 1'b1, (m < 14), (m >= 1), 8'd1);

    foreach (tbl[i]) begin
      rst    = tbl[i].rst;
      locked = tbl[i].locked;
      step();
      chk_outs(tbl[i].name, tbl[i].e_ro, tbl[i].e_lost);
      chk({tbl[i].name, ".locked_sync"}, int'(locked_sync), int'(tbl[i].e_sync));
    end

    // Saturation: 260 more losses from RUN. The counter must stop at 255.
    for (int j = 2; j <= 261; j++)
      loss_cycle((j - 1 > 255) ? 255 : j - 1, (j > 255) ? 255 : j);

    // rst asserted while in HOLD. The preceding loss from RUN keeps the counter saturated,
    // and rst then clears it.
    locked = 1'b0;
    step();
    chk_outs("rsthold.l1", 1'b0, 8'd255);
    locked = 1'b1;
    step();
    repeat (11) step();
    chk_outs("rsthold.e12", 1'b1, 8'd255);
    rst = 1'b1;
    step();
    chk_outs("rsthold.rst", 1'b1, 8'd0);
    chk("rsthold.locked_sync", int'(locked_sync), 0);
    rst = 1'b0;
    step();
    chk_outs("rsthold.e1", 1'b1, 8'd0);
    repeat (13) step();
    chk_outs("rsthold.e14", 1'b1, 8'd0);
    step();
    chk_outs("rsthold.release", 1'b0, 8'd0);

    // Collision: rst is held over the edge where locked_sync falls and over the edge where
    // RUN would detect the loss. The loss must not be counted, and the earlier count clears.
    loss_cycle(0, 1);
    locked = 1'b0;
    step();
    chk_outs("coll.l1", 1'b0, 8'd1);
    rst = 1'b1;
    step();
    chk_outs("coll.l2", 1'b1, 8'd0);
    step();
    chk_outs("coll.l3", 1'b1, 8'd0);
    chk("coll.locked_sync", int'(locked_sync), 0);
    rst = 1'b0;
    step();
    step();
    chk_outs("coll.idle", 1'b1, 8'd0);
    locked = 1'b1;
    step();
    chk_outs("coll.e1", 1'b1, 8'd0);
    repeat (13) step();
    chk_outs("coll.e14", 1'b1, 8'd0);
    step();
    chk_outs("coll.release", 1'b0, 8'd0);

    // Default parameters: release 2+1024+16 = 1042 edges after the first high sample.
    step();
    step();
    chk("def.rst.rst_out", int'(rst_out_d), 1);
    chk("def.rst.ready", int'(ready_d), 0);
    chk("def.rst.lost_cnt", int'(lost_cnt_d), 0);
    chk("def.rst.locked_sync", int'(locked_sync_d), 0);
    rst_d = 1'b0;
    step();
    locked_d = 1'b1;
    step();
    chk("def.e1.rst_out", int'(rst_out_d), 1);
    n = 0;
    while (rst_out_d && (n < 2000)) begin
      step();
      n++;
    end
    chk("def.latency", n, 1042);
    chk("def.ready", int'(ready_d), 1);
    chk("def.lost_cnt", int'(lost_cnt_d), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
